// File: rtl/apu_pkg.sv
// Shared APU definitions: register read masks, length-counter width default and the NR44 control bits.
package apu_pkg;

    localparam int LEN_BITS_DEF = 6;

    // A set mask bit marks a read-back bit that returns the fill value instead of register state.
    localparam logic [7:0] FF20_RD_MASK = 8'hFF;
    localparam logic [7:0] FF21_RD_MASK = 8'h00;
    localparam logic [7:0] FF22_RD_MASK = 8'h00;
    localparam logic [7:0] FF23_RD_MASK = 8'hBF;

    typedef struct packed {
        logic trig;
        logic len_en;
    } nr44_t;

endpackage

// File: rtl/ch4_len_counter.sv
// Noise-channel length timer: counts len_tick pulses up to wrap and flags expiry on fugo_q.
// Optional extra-increment behaviour is built when CH4_LEN_QUIRK_EN is defined.
module ch4_len_counter
    import apu_pkg::*;
#(
    parameter int LEN_BITS = LEN_BITS_DEF
) (
    input  logic                dova_phi,
    input  logic                apu_reset,
    input  logic                load_i,
    input  logic [LEN_BITS-1:0] load_val_i,
    input  logic                wr23_i,
    input  logic                trig_i,
    input  logic                len_en_i,
    input  logic                len_en_new_i,
    input  logic                len_tick,
    input  logic                len_phase,
    output logic                fugo_q
);

    logic [LEN_BITS-1:0] len_cnt_q, len_cnt_d;
    logic                fugo_d;
    logic [LEN_BITS-1:0] cnt_inc;
    logic                cnt_max;
    logic                quirk_inc;

    assign cnt_inc = len_cnt_q + {{(LEN_BITS-1){1'b0}}, 1'b1};
    assign cnt_max = &len_cnt_q;

`ifdef CH4_LEN_QUIRK_EN
    // Enabling length while the sequencer is in its non-clocking half clocks it once immediately.
    assign quirk_inc = wr23_i && !len_en_i && len_en_new_i && len_phase && !fugo_q;
`else
    logic unused_quirk;
    assign unused_quirk = len_phase ^ len_en_new_i;
    assign quirk_inc    = 1'b0;
`endif

    always_comb begin
        len_cnt_d = len_cnt_q;
        fugo_d    = fugo_q;
        if (load_i) begin
            len_cnt_d = load_val_i;
            fugo_d    = 1'b0;
        end else if (trig_i && fugo_q) begin
            len_cnt_d = '0;
            fugo_d    = 1'b0;
        end else if (quirk_inc) begin
            // A wrap here lands on 0, which is also the trigger reload value; only fugo differs.
            len_cnt_d = cnt_inc;
            fugo_d    = cnt_max && !trig_i;
        end else if (len_tick && len_en_i && !fugo_q && !wr23_i) begin
            len_cnt_d = cnt_inc;
            fugo_d    = cnt_max;
        end
    end

    always_ff @(posedge dova_phi or posedge apu_reset) begin
        if (apu_reset) begin
            len_cnt_q <= '0;
            fugo_q    <= 1'b0;
        end else begin
            len_cnt_q <= len_cnt_d;
            fugo_q    <= fugo_d;
        end
    end

endmodule

// File: rtl/ch4_ctrl_regs.sv
// Noise-channel NR41..NR44 register file, trigger handshake and CPU read-back.
// Define CH4_LEN_QUIRK_EN to build the length-enable extra-increment behaviour.
module ch4_ctrl_regs
    import apu_pkg::*;
#(
    parameter int   LEN_BITS = LEN_BITS_DEF,
    parameter logic RD_FILL  = 1'b1
) (
    input  logic       dova_phi,
    input  logic       apu_reset,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic       ff20,
    input  logic       ff21,
    input  logic       ff22,
    input  logic       ff23,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic [7:0] ff21_q,
    output logic [7:0] ff22_q,
    output logic       ff23_d6,
    output logic       ff23_d7,
    input  logic       rst_ff23_d7,
    input  logic       len_tick,
    input  logic       len_phase,
    output logic       fugo_q
);

    logic       wr20, wr21, wr22, wr23, trig;
    logic [7:0] ff21_d, ff22_d;
    nr44_t      nr44_q, nr44_d;
    logic [7:0] rd_raw, rd_mask;

    assign wr20 = cpu_wr && ff20;
    assign wr21 = cpu_wr && ff21;
    assign wr22 = cpu_wr && ff22;
    assign wr23 = cpu_wr && ff23;
    assign trig = wr23 && d_in[7];

    always_comb begin
        ff21_d = wr21 ? d_in : ff21_q;
        ff22_d = wr22 ? d_in : ff22_q;
        nr44_d = nr44_q;
        if (wr23) nr44_d.len_en = d_in[6];
        // A new trigger outranks a same-cycle acknowledge so the request is never lost.
        if (trig)              nr44_d.trig = 1'b1;
        else if (!rst_ff23_d7) nr44_d.trig = 1'b0;
    end

    always_ff @(posedge dova_phi or posedge apu_reset) begin
        if (apu_reset) begin
            ff21_q <= 8'h00;
            ff22_q <= 8'h00;
            nr44_q <= '0;
        end else begin
            ff21_q <= ff21_d;
            ff22_q <= ff22_d;
            nr44_q <= nr44_d;
        end
    end

    assign ff23_d6 = nr44_q.len_en;
    assign ff23_d7 = nr44_q.trig;

    ch4_len_counter #(.LEN_BITS(LEN_BITS)) u_len (
        .dova_phi     (dova_phi),
        .apu_reset    (apu_reset),
        .load_i       (wr20),
        .load_val_i   (d_in[LEN_BITS-1:0]),
        .wr23_i       (wr23),
        .trig_i       (trig),
        .len_en_i     (nr44_q.len_en),
        .len_en_new_i (d_in[6]),
        .len_tick     (len_tick),
        .len_phase    (len_phase),
        .fugo_q       (fugo_q)
    );

    assign d_oe = cpu_rd && (ff20 || ff21 || ff22 || ff23);

    always_comb begin
        rd_raw  = 8'h00;
        rd_mask = 8'h00;
        if (ff20) begin
            rd_mask = FF20_RD_MASK;
        end else if (ff21) begin
            rd_raw  = ff21_q;
            rd_mask = FF21_RD_MASK;
        end else if (ff22) begin
            rd_raw  = ff22_q;
            rd_mask = FF22_RD_MASK;
        end else if (ff23) begin
            rd_raw  = {1'b0, nr44_q.len_en, 6'b000000};
            rd_mask = FF23_RD_MASK;
        end
        d_out = d_oe ? ((rd_raw & ~rd_mask) | ({8{RD_FILL}} & rd_mask)) : 8'h00;
    end

endmodule

// File: tb/tb_ch4_ctrl_regs.sv
// Directed self-checking bench for ch4_ctrl_regs; quirk expectations follow CH4_LEN_QUIRK_EN.
module tb_ch4_ctrl_regs;

  logic       dova_phi = 1'b0;
  logic       apu_reset = 1'b0;
  logic       cpu_wr = 1'b0;
  logic       cpu_rd = 1'b0;
  logic       ff20 = 1'b0, ff21 = 1'b0, ff22 = 1'b0, ff23 = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] ff21_q, ff22_q;
  logic       ff23_d6, ff23_d7;
  logic       rst_ff23_d7 = 1'b1;
  logic       len_tick = 1'b0;
  logic       len_phase = 1'b0;
  logic       fugo_q;

  int checks = 0;
  int failures = 0;

  ch4_ctrl_regs dut (
    .dova_phi    (dova_phi),
    .apu_reset   (apu_reset),
    .cpu_wr      (cpu_wr),
    .cpu_rd      (cpu_rd),
    .ff20        (ff20),
    .ff21        (ff21),
    .ff22        (ff22),
    .ff23        (ff23),
    .d_in        (d_in),
    .d_out       (d_out),
    .d_oe        (d_oe),
    .ff21_q      (ff21_q),
    .ff22_q      (ff22_q),
    .ff23_d6     (ff23_d6),
    .ff23_d7     (ff23_d7),
    .rst_ff23_d7 (rst_ff23_d7),
    .len_tick    (len_tick),
    .len_phase   (len_phase),
    .fugo_q      (fugo_q)
  );

  // clock / reset
  always #5 dova_phi = ~dova_phi;

  task automatic do_reset();
    @(negedge dova_phi);
    apu_reset = 1'b1;
    @(negedge dova_phi);
    @(negedge dova_phi);
    apu_reset = 1'b0;
  endtask

  // checker
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic set_sel(input int sel);
    ff20 = (sel == 0);
    ff21 = (sel == 1);
    ff22 = (sel == 2);
    ff23 = (sel == 3);
  endtask

  task automatic cpu_write(input int sel, input logic [7:0] data, input logic with_tick);
    @(negedge dova_phi);
    set_sel(sel);
    d_in = data;
    cpu_wr = 1'b1;
    len_tick = with_tick;
    @(negedge dova_phi);
    cpu_wr = 1'b0;
    len_tick = 1'b0;
    set_sel(-1);
    d_in = 8'h00;
  endtask

  task automatic cpu_read(input int sel, input string tag, input logic [7:0] exp);
    @(negedge dova_phi);
    set_sel(sel);
    cpu_rd = 1'b1;
    #1;
    check({tag, "_oe"}, {7'b0, d_oe}, 8'h01);
    check(tag, d_out, exp);
    cpu_rd = 1'b0;
    set_sel(-1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge dova_phi);
      len_tick = 1'b1;
      @(negedge dova_phi);
      len_tick = 1'b0;
    end
  endtask

  task automatic ack_trigger();
    @(negedge dova_phi);
    rst_ff23_d7 = 1'b0;
    @(negedge dova_phi);
    rst_ff23_d7 = 1'b1;
  endtask

  logic quirk_fugo_exp;
  logic quirk_trig_tick_exp;

  initial begin
`ifdef CH4_LEN_QUIRK_EN
    quirk_fugo_exp      = 1'b1;
    quirk_trig_tick_exp = 1'b0;
`else
    quirk_fugo_exp      = 1'b0;
    quirk_trig_tick_exp = 1'b1;
`endif

    // reset state
    @(negedge dova_phi);
    apu_reset = 1'b1;
    @(negedge dova_phi);
    check("rst_ff21", ff21_q, 8'h00);
    check("rst_ff22", ff22_q, 8'h00);
    check("rst_d6", {7'b0, ff23_d6}, 8'h00);
    check("rst_d7", {7'b0, ff23_d7}, 8'h00);
    check("rst_fugo", {7'b0, fugo_q}, 8'h00);
    check("rst_oe", {7'b0, d_oe}, 8'h00);
    check("rst_dout", d_out, 8'h00);
    apu_reset = 1'b0;
    cpu_read(3, "rd_ff23_rst", 8'hBF);
    cpu_read(0, "rd_ff20", 8'hFF);

    // NR41 / NR42 write and read-back
    cpu_write(1, 8'hA5, 1'b0);
    check("ff21_q", ff21_q, 8'hA5);
    cpu_write(2, 8'h3C, 1'b0);
    check("ff22_q", ff22_q, 8'h3C);
    check("ff21_hold", ff21_q, 8'hA5);
    cpu_read(1, "rd_ff21", 8'hA5);
    cpu_read(2, "rd_ff22", 8'h3C);

    // length expiry after two ticks from 3E
    cpu_write(0, 8'h3E, 1'b0);
    cpu_write(3, 8'h40, 1'b0);
    check("len_en", {7'b0, ff23_d6}, 8'h01);
    check("no_trig", {7'b0, ff23_d7}, 8'h00);
    cpu_read(3, "rd_ff23_en", 8'hFF);
    ticks(1);
    check("fugo_tick1", {7'b0, fugo_q}, 8'h00);
    ticks(1);
    check("fugo_tick2", {7'b0, fugo_q}, 8'h01);
    ticks(3);
    check("fugo_sticky", {7'b0, fugo_q}, 8'h01);

    // trigger handshake; the trigger also reloads the expired counter
    cpu_write(3, 8'h80, 1'b0);
    check("trig_set", {7'b0, ff23_d7}, 8'h01);
    check("trig_reload_fugo", {7'b0, fugo_q}, 8'h00);
    check("trig_d6_clr", {7'b0, ff23_d6}, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge dova_phi);
      check("trig_hold", {7'b0, ff23_d7}, 8'h01);
    end
    ack_trigger();
    check("trig_ack", {7'b0, ff23_d7}, 8'h00);

    // trigger write wins over a same-cycle acknowledge
    @(negedge dova_phi);
    set_sel(3);
    d_in = 8'h80;
    cpu_wr = 1'b1;
    rst_ff23_d7 = 1'b0;
    @(negedge dova_phi);
    cpu_wr = 1'b0;
    set_sel(-1);
    rst_ff23_d7 = 1'b1;
    check("trig_vs_ack", {7'b0, ff23_d7}, 8'h01);
    ack_trigger();

    // expire, then trigger with length enabled: exactly 64 ticks to expire again
    cpu_write(0, 8'h3F, 1'b0);
    cpu_write(3, 8'h40, 1'b0);
    ticks(1);
    check("fugo_from_3f", {7'b0, fugo_q}, 8'h01);
    cpu_write(3, 8'hC0, 1'b0);
    check("retrig_fugo", {7'b0, fugo_q}, 8'h00);
    check("retrig_d7", {7'b0, ff23_d7}, 8'h01);
    ack_trigger();
    ticks(63);
    check("fugo_63", {7'b0, fugo_q}, 8'h00);
    ticks(1);
    check("fugo_64", {7'b0, fugo_q}, 8'h01);

    // tick coincident with FF23 / FF20 writes is dropped
    cpu_write(0, 8'h3F, 1'b0);
    cpu_write(3, 8'h40, 1'b1);
    check("tick_drop_ff23", {7'b0, fugo_q}, 8'h00);
    cpu_write(0, 8'h3F, 1'b1);
    check("tick_drop_ff20", {7'b0, fugo_q}, 8'h00);
    ticks(1);
    check("tick_after_drop", {7'b0, fugo_q}, 8'h01);

    // FF20 write clears an expired counter
    cpu_write(0, 8'h3E, 1'b0);
    check("ff20_clr_fugo", {7'b0, fugo_q}, 8'h00);

    // mid-operation reset clears a pending trigger asynchronously
    cpu_write(3, 8'hC0, 1'b0);
    check("pre_rst_d7", {7'b0, ff23_d7}, 8'h01);
    @(negedge dova_phi);
    #2;
    apu_reset = 1'b1;
    #1;
    check("async_rst_d7", {7'b0, ff23_d7}, 8'h00);
    check("async_rst_d6", {7'b0, ff23_d6}, 8'h00);
    check("async_rst_ff21", ff21_q, 8'h00);
    @(negedge dova_phi);
    apu_reset = 1'b0;

    // enabling length while len_phase=1
    cpu_write(0, 8'h3F, 1'b0);
    @(negedge dova_phi);
    len_phase = 1'b1;
    cpu_write(3, 8'h40, 1'b0);
    len_phase = 1'b0;
    check("quirk_fugo", {7'b0, fugo_q}, {7'b0, quirk_fugo_exp});

    // same, but the enabling write also triggers
    do_reset();
    cpu_write(0, 8'h3F, 1'b0);
    len_phase = 1'b1;
    cpu_write(3, 8'hC0, 1'b0);
    len_phase = 1'b0;
    check("quirk_trig_fugo", {7'b0, fugo_q}, 8'h00);
    ack_trigger();
    ticks(1);
    check("quirk_trig_tick", {7'b0, fugo_q}, {7'b0, quirk_trig_tick_exp});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
